// File: rtl/generator_ctrl.sv
// generator_ctrl: sequences noise requests through an external generator, with
// double-buffered Q8.8 weights committed only while idle, a timeout and a response handshake.
module generator_ctrl #(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_wr_en,
  input  logic [5:0]          cfg_addr,
  input  logic [15:0]         cfg_data,
  input  logic                cfg_commit,
  output logic                cfg_pending,
  output logic                cfg_err,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic signed [15:0]  req_z1,
  input  logic signed [15:0]  req_z2,
  output logic                gen_valid_in,
  output logic [15:0]         gen_z1,
  output logic [15:0]         gen_z2,
  output logic [143:0]        gen_w_L1,
  output logic [575:0]        gen_w_L2,
  input  logic                gen_valid_out,
  input  logic [143:0]        gen_pix,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [143:0]        rsp_pix,
  output logic                rsp_err,
  output logic                busy,
  output logic [15:0]         infer_cnt
);
  localparam int TW = $clog2(TIMEOUT_CYC) + 1;
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, DONE} state_t;
  state_t        r_state;
  logic [15:0]   r_shadow [45];
  logic [15:0]   r_active [45];
  logic [15:0]   r_z1, r_z2, r_cnt;
  logic [143:0]  r_pix;
  logic          r_err, r_pending, r_cfg_err;
  logic [TW-1:0] r_tmo;
  logic          w_idle;
  assign w_idle       = r_state == IDLE;
  assign req_ready    = w_idle & !cfg_commit & !r_pending & !rst;
  assign gen_valid_in = r_state == LAUNCH;
  assign rsp_valid    = r_state == DONE;
  assign busy         = !w_idle;
  assign gen_z1       = r_z1;
  assign gen_z2       = r_z2;
  assign rsp_pix      = r_pix;
  assign rsp_err      = r_err;
  assign infer_cnt    = r_cnt;
  assign cfg_pending  = r_pending;
  assign cfg_err      = r_cfg_err;
  for (genvar k = 0; k < 9; k++) begin : g_l1
    assign gen_w_L1[16*k +: 16] = r_active[k];
  end
  for (genvar k = 0; k < 36; k++) begin : g_l2
    assign gen_w_L2[16*k +: 16] = r_active[k+9];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_z1      <= '0;
      r_z2      <= '0;
      r_pix     <= '0;
      r_err     <= 1'b0;
      r_cnt     <= '0;
      r_tmo     <= '0;
      r_pending <= 1'b0;
      r_cfg_err <= 1'b0;
      for (int i = 0; i < 45; i++) begin
        r_shadow[i] <= '0;
        r_active[i] <= '0;
      end
    end else begin
      r_cfg_err <= cfg_wr_en && cfg_addr > 6'd44;
      if (cfg_wr_en && cfg_addr <= 6'd44) r_shadow[cfg_addr] <= cfg_data;
      // Active copy reads the pre-edge shadow, so a same-cycle write stays shadow-only
      if (w_idle && (cfg_commit || r_pending)) begin
        r_active  <= r_shadow;
        r_pending <= 1'b0;
      end else if (cfg_commit) begin
        r_pending <= 1'b1;
      end
      case (r_state)
        IDLE: if (req_valid && req_ready) begin
          r_z1    <= req_z1;
          r_z2    <= req_z2;
          r_state <= LAUNCH;
        end
        LAUNCH: begin
          r_tmo   <= '0;
          r_state <= WAIT;
        end
        WAIT: if (gen_valid_out) begin
          r_pix   <= gen_pix;
          r_err   <= 1'b0;
          r_cnt   <= r_cnt == 16'hFFFF ? r_cnt : r_cnt + 16'd1;
          r_state <= DONE;
        end else if (r_tmo == TW'(TIMEOUT_CYC - 1)) begin
          r_pix   <= '0;
          r_err   <= 1'b1;
          r_state <= DONE;
        end else begin
          r_tmo <= r_tmo + TW'(1);
        end
        DONE: if (rsp_ready) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_generator_ctrl.sv
// tb_generator_ctrl: randomized transactions against a transaction-level model of
// weights, commit deferral, latency/timeout and inference count.
module tb_generator_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, cfg_wr_en, cfg_commit, cfg_pending, cfg_err, req_valid, req_ready;
  logic [5:0] cfg_addr;
  logic [15:0] cfg_data, gen_z1, gen_z2, infer_cnt;
  logic signed [15:0] req_z1, req_z2;
  logic gen_valid_in, gen_valid_out, rsp_valid, rsp_ready, rsp_err, busy;
  logic [143:0] gen_w_L1, gen_pix, rsp_pix;
  logic [575:0] gen_w_L2;

  generator_ctrl #(.TIMEOUT_CYC(64)) dut (
    .clk(clk), .rst(rst), .cfg_wr_en(cfg_wr_en), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_commit(cfg_commit), .cfg_pending(cfg_pending), .cfg_err(cfg_err),
    .req_valid(req_valid), .req_ready(req_ready), .req_z1(req_z1), .req_z2(req_z2),
    .gen_valid_in(gen_valid_in), .gen_z1(gen_z1), .gen_z2(gen_z2),
    .gen_w_L1(gen_w_L1), .gen_w_L2(gen_w_L2), .gen_valid_out(gen_valid_out), .gen_pix(gen_pix),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_pix(rsp_pix), .rsp_err(rsp_err),
    .busy(busy), .infer_cnt(infer_cnt));

  logic [15:0] m_sh [45];
  logic [15:0] m_act [45];
  bit m_pend;
  int m_cnt, n_cmp, n_err;

  task automatic chk(input string tag, input logic [575:0] got, input logic [575:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [575:0] exp_l1();
    logic [575:0] v = '0;
    for (int k = 0; k < 9; k++) v[16*k +: 16] = m_act[k];
    return v;
  endfunction

  function automatic logic [575:0] exp_l2();
    logic [575:0] v = '0;
    for (int k = 0; k < 36; k++) v[16*k +: 16] = m_act[k+9];
    return v;
  endfunction

  function automatic logic [143:0] rnd144();
    logic [159:0] v = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return v[143:0];
  endfunction

  task automatic chk_w(input string tag);
    chk({tag, "_L1"}, gen_w_L1, exp_l1());
    chk({tag, "_L2"}, gen_w_L2, exp_l2());
  endtask

  task automatic model_reset();
    for (int i = 0; i < 45; i++) begin
      m_sh[i] = '0;
      m_act[i] = '0;
    end
    m_pend = 0;
    m_cnt = 0;
  endtask

  // One idle-state config cycle: commit takes the pre-edge shadow, then the write lands
  task automatic cfg_cycle(input bit wr, input int addr, input logic [15:0] d, input bit commit);
    cfg_wr_en = wr; cfg_addr = 6'(addr); cfg_data = d; cfg_commit = commit;
    #1 chk("req_ready_vs_commit", req_ready, !commit);
    @(negedge clk);
    cfg_wr_en = 0; cfg_commit = 0;
    if (commit) m_act = m_sh;
    if (wr && addr <= 44) m_sh[addr] = d;
    chk("cfg_err", cfg_err, wr && addr > 44);
    chk("cfg_pending_idle", cfg_pending, 0);
    chk_w("w_cfg");
  endtask

  task automatic run_req(input logic [15:0] z1, z2, input int lat, hold, cmt_t, wr_t,
                         input logic [143:0] pix, input bit spur);
    logic [143:0] pix_exp;
    int t_rv, exp_t;
    bit ok;
    pix_exp = '0;
    t_rv = 0;
    rsp_ready = hold == 0;
    for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1; req_z1 = z1; req_z2 = z2;
    @(negedge clk);
    req_valid = 0; req_z1 = 16'($urandom); req_z2 = 16'($urandom);
    chk("gen_valid_in_launch", gen_valid_in, 1);
    chk("gen_z1", gen_z1, z1);
    chk("gen_z2", gen_z2, z2);
    chk("busy_launch", busy, 1);
    gen_valid_out = spur;
    gen_pix = rnd144();
    for (int t = 1; t <= 100; t++) begin
      @(negedge clk);
      if (rsp_valid) begin
        t_rv = t;
        break;
      end
      if (gen_valid_in || gen_z1 !== z1 || gen_z2 !== z2) chk("launch_hold", {gen_valid_in, gen_z1, gen_z2}, {1'b0, z1, z2});
      gen_valid_out = t == lat;
      gen_pix = t == lat ? pix : rnd144();
      if (t == lat) pix_exp = pix;
      cfg_commit = t == cmt_t;
      if (t == cmt_t) m_pend = 1;
      cfg_wr_en = t == wr_t;
      if (t == wr_t) begin
        cfg_addr = 6'($urandom_range(0, 44));
        cfg_data = 16'($urandom);
        m_sh[cfg_addr] = cfg_data;
      end
    end
    gen_valid_out = 0; cfg_commit = 0; cfg_wr_en = 0;
    ok = lat >= 1 && lat <= 64;
    exp_t = ok ? lat + 1 : 65;
    if (ok && m_cnt < 65535) m_cnt++;
    chk("rsp_latency", t_rv, exp_t);
    chk("rsp_pix", rsp_pix, ok ? pix_exp : '0);
    chk("rsp_err", rsp_err, !ok);
    chk("infer_cnt", infer_cnt, m_cnt);
    chk("cfg_pending_busy", cfg_pending, m_pend);
    chk_w("w_busy");
    for (int h = 0; h < hold; h++) begin
      req_valid = 1;
      gen_valid_out = 1'($urandom);
      gen_pix = rnd144();
      @(negedge clk);
      if (!rsp_valid || rsp_pix !== (ok ? pix_exp : '0) || req_ready || gen_valid_in)
        chk("backpressure", {rsp_valid, req_ready, gen_valid_in, rsp_pix}, {3'b100, ok ? pix_exp : 144'h0});
    end
    req_valid = 0; gen_valid_out = 0; rsp_ready = 1;
    if (hold > 0) @(negedge clk);
    else @(negedge clk);
    chk("rsp_valid_after", rsp_valid, 0);
    chk("busy_after", busy, 0);
    chk("no_relaunch", gen_valid_in, 0);
    chk("infer_cnt_after", infer_cnt, m_cnt);
    chk("req_ready_first_idle", req_ready, !m_pend);
    chk_w("w_first_idle");
    if (m_pend) begin
      @(negedge clk);
      m_act = m_sh;
      m_pend = 0;
      chk("cfg_pending_clear", cfg_pending, 0);
      chk_w("w_deferred");
    end
  endtask

  task automatic reset_mid_wait();
    run_start:
    begin
      rsp_ready = 1;
      for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
      req_valid = 1; req_z1 = 16'h1234; req_z2 = 16'h5678;
      @(negedge clk);
      req_valid = 0;
      repeat (2) @(negedge clk);
      cfg_commit = 1;
      @(negedge clk);
      cfg_commit = 0;
      chk("pending_before_rst", cfg_pending, 1);
      @(negedge clk);
      rst = 1;
      #1 chk("req_ready_in_rst", req_ready, 0);
      @(negedge clk);
      rst = 0;
      model_reset();
      chk("rst_outs", {busy, rsp_valid, gen_valid_in, cfg_pending, cfg_err, rsp_err}, 0);
      chk("rst_data", {rsp_pix, gen_z1, gen_z2, infer_cnt}, 0);
      chk_w("w_rst");
      gen_valid_out = 1; gen_pix = rnd144();
      @(negedge clk);
      gen_valid_out = 0;
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        chk("late_gen_ignored", {rsp_valid, busy, infer_cnt, cfg_pending}, 0);
      end
    end
  endtask

  initial begin
    logic [143:0] seq;
    n_cmp = 0; n_err = 0;
    rst = 1; cfg_wr_en = 0; cfg_addr = 0; cfg_data = 0; cfg_commit = 0;
    req_valid = 0; req_z1 = 0; req_z2 = 0; gen_valid_out = 0; gen_pix = 0; rsp_ready = 1;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_outs", {busy, rsp_valid, gen_valid_in, req_ready, cfg_err, cfg_pending, rsp_err}, 0);
    chk("reset_data", {infer_cnt, rsp_pix, gen_z1, gen_z2}, 0);
    chk_w("w_reset");
    rst = 0;
    @(negedge clk);
    chk("req_ready_after_reset", req_ready, 1);
    cfg_cycle(1, 0, 16'h0100, 0);
    cfg_cycle(1, 44, 16'hFF00, 0);
    cfg_cycle(0, 0, 16'h0, 1);
    chk("w_addr0", gen_w_L1[15:0], 16'h0100);
    chk("w_addr44", gen_w_L2[575:560], 16'hFF00);
    cfg_cycle(1, 45, 16'h1234, 0);
    @(negedge clk);
    chk("cfg_err_one_cycle", cfg_err, 0);
    cfg_cycle(0, 0, 16'h0, 1);
    cfg_cycle(1, 3, 16'hABCD, 1);
    cfg_cycle(0, 0, 16'h0, 1);
    for (int k = 0; k < 9; k++) seq[16*k +: 16] = 16'(17 * (k + 1));
    run_req(16'h0080, 16'hFF80, 4, 10, 2, 3, seq, 0);
    run_req(16'h7FFF, 16'h8000, 0, 0, 0, 0, rnd144(), 1);
    run_req(16'h0001, 16'h0002, 64, 2, 0, 0, rnd144(), 0);
    for (int n = 0; n < 24; n++) begin
      int lat, lim;
      repeat ($urandom_range(0, 3))
        cfg_cycle(1'($urandom), $urandom_range(0, 47), 16'($urandom), $urandom_range(0, 3) == 0);
      case ($urandom_range(0, 5))
        0: lat = 64;
        1: lat = 65;
        2: lat = 0;
        default: lat = $urandom_range(1, 8);
      endcase
      lim = (lat >= 1 && lat <= 64) ? lat : 64;
      run_req(16'($urandom), 16'($urandom), lat, $urandom_range(0, 10),
              $urandom_range(0, 1) ? $urandom_range(1, lim) : 0,
              $urandom_range(0, 1) ? $urandom_range(1, lim) : 0, rnd144(), 1'($urandom));
    end
    reset_mid_wait();
    run_req(16'h0042, 16'h0043, 3, 1, 1, 2, rnd144(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
